// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_arb_pkg : shared types for the unified memory-port arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [1:0] FMT_WORD = 2'b00;
  localparam logic [1:0] FMT_HALF = 2'b01;
  localparam logic [1:0] FMT_BYTE = 2'b10;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_be_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// be_gen : byte enables, store-data lane replication and alignment check
// Rev 1.0
// ---------------------------------------------------------------------------
module be_gen
  import mem_arb_pkg::*;
(
  input  logic [1:0]  fmt,
  input  logic [1:0]  addr_lo,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic        misalign
);

  // Reserved fmt falls through to word handling.
  always_comb begin
    be        = 4'b1111;
    wdata_rep = wdata;
    misalign  = (addr_lo != 2'b00);
    case (fmt)
      FMT_HALF: begin
        misalign  = addr_lo[0];
        wdata_rep = {2{wdata[15:0]}};
        if (we) be = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      FMT_BYTE: begin
        misalign  = 1'b0;
        wdata_rep = {4{wdata[7:0]}};
        if (we) be = 4'b0001 << addr_lo;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_arbiter : round-robin share of one memory port between fetch and data
// Rev 1.0
// ---------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_fmt,
  output logic        d_ack,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] C_MAX_WAIT = CW'(MAX_WAIT);

  state_t        state_q, state_d;
  owner_t        owner_q, owner_d, last_grant_q, last_grant_d, win;
  logic          err_q, err_d, we_q, we_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d;
  logic [31:0]   if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic [3:0]    be_q, be_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;

  logic          grant, sel_we, sel_misalign;
  logic [1:0]    sel_fmt;
  logic [31:0]   sel_addr, sel_wdata;
  logic [3:0]    sel_be;

  // On a tie the requester not served last wins.
  always_comb begin
    grant = if_req | d_req;
    if (if_req && d_req) win = (last_grant_q == OWN_IF) ? OWN_D : OWN_IF;
    else if (d_req)      win = OWN_D;
    else                 win = OWN_IF;
  end

  assign sel_addr  = (win == OWN_IF) ? if_addr : d_addr;
  assign sel_we    = (win == OWN_D) && d_we;
  assign sel_fmt   = (win == OWN_IF) ? FMT_WORD : d_fmt;

  be_gen u_be_gen (
    .fmt       (sel_fmt),
    .addr_lo   (sel_addr[1:0]),
    .we        (sel_we),
    .wdata     (d_wdata),
    .be        (sel_be),
    .wdata_rep (sel_wdata),
    .misalign  (sel_misalign)
  );

  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    err_d        = err_q;
    we_d         = we_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          owner_d      = win;
          last_grant_d = win;
          addr_d       = {sel_addr[31:2], 2'b00};
          we_d         = sel_we;
          be_d         = sel_be;
          wdata_d      = sel_wdata;
          cnt_d        = '0;
          err_d        = sel_misalign;
          state_d      = sel_misalign ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        cnt_d = cnt_inc;
        if (mem_ready) begin
          err_d   = 1'b0;
          state_d = ST_RESP;
          if (!we_q) begin
            if (owner_q == OWN_IF) if_rdata_d = mem_rdata;
            else                   d_rdata_d  = mem_rdata;
          end
        end else if (cnt_inc == C_MAX_WAIT) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_IF;
      last_grant_q <= OWN_D;
      err_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign mem_req   = (state_q == ST_ACCESS);
  assign mem_we    = mem_req & we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign if_ack    = (state_q == ST_RESP) && (owner_q == OWN_IF);
  assign d_ack     = (state_q == ST_RESP) && (owner_q == OWN_D);
  assign if_err    = if_ack & err_q;
  assign d_err     = d_ack & err_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_arbiter : randomized bench with a transaction-timing reference model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we, mem_ready;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [1:0]  d_fmt;
  logic        if_ack, if_err, d_ack, d_err, mem_req, mem_we;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_fmt(d_fmt),
    .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: each granted transaction is reduced to absolute cycle
  // numbers (access window, ready cycle, ack cycle) plus expected port values.
  int          free_at, ack_cyc, acc_first, acc_last, ready_cyc;
  int          forced_delay = -1;
  bit          cur_active, cur_d, cur_we, cur_err, last_d;
  logic [31:0] cur_addr, cur_wdata;
  logic [3:0]  cur_be;
  logic [31:0] m_if_rdata, m_d_rdata;
  bit          if_granted, d_granted, if_done, d_done, rand_mode;
  bit          fix_rd_en;
  logic [31:0] fix_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [3:0] exp_be(input logic we, input logic [1:0] fmt, input logic [1:0] a);
    if (!we) return 4'hF;
    if (fmt == 2'b01) return a[1] ? 4'b1100 : 4'b0011;
    if (fmt == 2'b10) return 4'b0001 << a;
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wd(input logic [1:0] fmt, input logic [31:0] w);
    if (fmt == 2'b10) return 32'h0101_0101 * {24'h0, w[7:0]};
    if (fmt == 2'b01) return 32'h0001_0001 * {16'h0, w[15:0]};
    return w;
  endfunction

  function automatic bit exp_misal(input logic [1:0] fmt, input logic [1:0] a);
    if (fmt == 2'b10) return 1'b0;
    if (fmt == 2'b01) return a[0];
    return a != 2'b00;
  endfunction

  task automatic new_if();
    if_req  = 1'b1;
    if_addr = {$urandom} & 32'hFFFF_FFFC;
    if ($urandom_range(0, 4) == 0) if_addr[1:0] = 2'($urandom_range(0, 3));
  endtask

  task automatic new_d();
    d_req   = 1'b1;
    d_we    = 1'($urandom_range(0, 1));
    d_fmt   = 2'($urandom_range(0, 3));
    d_wdata = $urandom;
    d_addr  = {$urandom} & 32'hFFFF_FFFC;
    if ($urandom_range(0, 1) == 0) d_addr[1:0] = 2'($urandom_range(0, 3));
  endtask

  // One clock cycle: drive memory side, compare at negedge, advance model.
  task automatic step();
    bit in_acc, win_d;
    int e, dly, len;
    in_acc    = cur_active && cyc >= acc_first && cyc <= acc_last;
    mem_rdata = fix_rd_en ? fix_rd : $urandom;
    if (in_acc) mem_ready = (cyc == ready_cyc);
    else        mem_ready = ($urandom_range(0, 7) == 0);
    @(negedge clk);
    check("mem_req", mem_req, in_acc);
    check("mem_we", mem_we, in_acc && cur_we);
    if (in_acc) begin
      check("mem_addr", mem_addr, cur_addr);
      check("mem_be", mem_be, cur_be);
      if (cur_we) check("mem_wdata", mem_wdata, cur_wdata);
    end
    check("if_ack", if_ack, cur_active && cyc == ack_cyc && !cur_d);
    check("d_ack", d_ack, cur_active && cyc == ack_cyc && cur_d);
    if (cur_active && cyc == ack_cyc)
      check(cur_d ? "d_err" : "if_err", cur_d ? d_err : if_err, cur_err);
    check("if_rdata", if_rdata, m_if_rdata);
    check("d_rdata", d_rdata, m_d_rdata);

    if (in_acc && cyc == ready_cyc && !cur_we) begin
      if (cur_d) m_d_rdata = mem_rdata;
      else       m_if_rdata = mem_rdata;
    end
    if (cur_active && cyc == ack_cyc) begin
      cur_active = 1'b0;
      if (cur_d) begin d_done = 1'b1; d_granted = 1'b0; end
      else       begin if_done = 1'b1; if_granted = 1'b0; end
    end else if (!cur_active && cyc >= free_at && (if_req || d_req)) begin
      win_d      = (if_req && d_req) ? !last_d : d_req;
      last_d     = win_d;
      cur_d      = win_d;
      cur_active = 1'b1;
      e          = cyc + 1;
      if (win_d) begin
        cur_we    = d_we;
        cur_addr  = {d_addr[31:2], 2'b00};
        cur_be    = exp_be(d_we, d_fmt, d_addr[1:0]);
        cur_wdata = exp_wd(d_fmt, d_wdata);
        cur_err   = exp_misal(d_fmt, d_addr[1:0]);
        d_granted = 1'b1;
      end else begin
        cur_we     = 1'b0;
        cur_addr   = {if_addr[31:2], 2'b00};
        cur_be     = 4'hF;
        cur_wdata  = 32'h0;
        cur_err    = (if_addr[1:0] != 2'b00);
        if_granted = 1'b1;
      end
      acc_first = e;
      if (cur_err) begin
        acc_last  = e - 1;
        ready_cyc = -1;
        ack_cyc   = e;
      end else begin
        dly = (forced_delay >= 0) ? forced_delay :
              (($urandom_range(0, 7) == 0) ? MAX_WAIT : $urandom_range(0, MAX_WAIT - 1));
        forced_delay = -1;
        if (dly < MAX_WAIT) begin len = dly + 1; ready_cyc = e + dly; cur_err = 1'b0; end
        else                begin len = MAX_WAIT; ready_cyc = -1;     cur_err = 1'b1; end
        acc_last = e + len - 1;
        ack_cyc  = e + len;
      end
      free_at = ack_cyc + 1;
    end

    @(posedge clk);
    cyc++;
    #1;
    if (if_done) begin
      if_done = 1'b0; if_req = 1'b0;
      if (rand_mode && $urandom_range(0, 3) == 0) new_if();
    end
    if (d_done) begin
      d_done = 1'b0; d_req = 1'b0;
      if (rand_mode && $urandom_range(0, 3) == 0) new_d();
    end
    if (rand_mode) begin
      // Latched values must be used once granted, so scramble live inputs.
      if (if_granted && $urandom_range(0, 1) == 1) if_addr = $urandom;
      if (d_granted && $urandom_range(0, 1) == 1) begin
        d_addr = $urandom; d_wdata = $urandom;
        d_fmt  = 2'($urandom_range(0, 3)); d_we = 1'($urandom_range(0, 1));
      end
      if (!if_req && $urandom_range(0, 3) == 0) new_if();
      if (!d_req && $urandom_range(0, 3) == 0) new_d();
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((if_req || d_req || cur_active) && n < 200) begin
      step();
      n++;
    end
    check("drain_bound", (n < 200), 1);
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_fmt = 2'b00;
    mem_ready = 1'b0; mem_rdata = '0;
    cur_active = 1'b0; last_d = 1'b1; m_if_rdata = '0; m_d_rdata = '0;
    if_granted = 1'b0; d_granted = 1'b0; if_done = 1'b0; d_done = 1'b0;
    rand_mode = 1'b0; fix_rd_en = 1'b0; fix_rd = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_req", mem_req, 0);   check("rst_mem_we", mem_we, 0);
    check("rst_mem_be", mem_be, 0);     check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_if_ack", if_ack, 0);     check("rst_d_ack", d_ack, 0);
    check("rst_if_err", if_err, 0);     check("rst_d_err", d_err, 0);
    check("rst_if_rdata", if_rdata, 0); check("rst_d_rdata", d_rdata, 0);
    rst = 1'b0;
    free_at = cyc;

    // Two simultaneous pairs: fetch then data each time.
    repeat (2) begin
      if_req = 1'b1; if_addr = {$urandom} & 32'hFFFF_FFFC;
      d_req = 1'b1; d_we = 1'b0; d_fmt = 2'b00; d_addr = {$urandom} & 32'hFFFF_FFFC;
      drain();
    end

    // Zero-wait fetch with a known word.
    fix_rd_en = 1'b1; fix_rd = 32'h2408_0005; forced_delay = 0;
    if_req = 1'b1; if_addr = 32'h0000_3000;
    drain();
    fix_rd_en = 1'b0;
    check("fetch_rdata", if_rdata, 32'h2408_0005);

    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1002; d_wdata = 32'h0000_00AB; d_fmt = 2'b10;
    drain();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1002; d_wdata = 32'h1234_CDEF; d_fmt = 2'b01;
    drain();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1001; d_fmt = 2'b01;
    drain();
    forced_delay = MAX_WAIT;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000; d_fmt = 2'b00;
    drain();

    rand_mode = 1'b1;
    repeat (3000) step();
    rand_mode = 1'b0;
    drain();

    // Reset in the middle of a 3-wait-state fetch.
    forced_delay = 3;
    if_req = 1'b1; if_addr = 32'h0000_4000;
    step();
    step();
    check("pre_rst_mem_req", mem_req, 1);
    #1 rst = 1'b1;
    #1;
    check("arst_mem_req", mem_req, 0);   check("arst_mem_we", mem_we, 0);
    check("arst_mem_be", mem_be, 0);     check("arst_mem_addr", mem_addr, 0);
    check("arst_mem_wdata", mem_wdata, 0);
    check("arst_if_ack", if_ack, 0);     check("arst_d_ack", d_ack, 0);
    check("arst_if_rdata", if_rdata, 0); check("arst_d_rdata", d_rdata, 0);
    cur_active = 1'b0; if_granted = 1'b0; d_granted = 1'b0; if_done = 1'b0; d_done = 1'b0;
    if_req = 1'b0; d_req = 1'b0; last_d = 1'b1; m_if_rdata = '0; m_d_rdata = '0;
    forced_delay = -1;
    free_at = cyc;
    #1 rst = 1'b0;
    repeat (6) step();
    if_req = 1'b1; if_addr = 32'h0000_3004;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
